// File: rtl/reg_write_scheduler_pkg.sv
// Shared constants and grant encodings for the register-write scheduler.
package reg_write_scheduler_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int NREG   = 8;

   typedef logic gnt_t;
   localparam gnt_t GNT_ALU = 1'b0;
   localparam gnt_t GNT_MEM = 1'b1;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/reg_write_scheduler_if.sv
// Requester handshakes, core check/stall signals and the reg_file write bus.
interface reg_write_scheduler_if;
   import reg_write_scheduler_pkg::*;

   logic                alu_valid;
   addr_t               alu_addr;
   data_t               alu_data;
   logic                alu_ready;
   logic                mem_valid;
   addr_t               mem_addr;
   data_t               mem_data;
   logic                mem_ready;
   logic                load_issue;
   addr_t               load_addr;
   logic                chk_en1;
   logic                chk_en2;
   addr_t               chk_addr1;
   addr_t               chk_addr2;
   logic                stall;
   logic                write;
   addr_t               inaddress;
   data_t               in_data;
   logic [NREG-1:0]     busy_mask;
   logic                err;

   // Core / requester side
   modport master (
      output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
             load_issue, load_addr, chk_en1, chk_en2, chk_addr1, chk_addr2,
      input  alu_ready, mem_ready, stall, write, inaddress, in_data,
             busy_mask, err
   );

   // Scheduler side
   modport slave (
      input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
             load_issue, load_addr, chk_en1, chk_en2, chk_addr1, chk_addr2,
      output alu_ready, mem_ready, stall, write, inaddress, in_data,
             busy_mask, err
   );
endinterface

// File: rtl/reg_write_scheduler_wb_arb_rr2.sv
// Two-requester round-robin arbiter; grants are one-hot, indexed by GNT_ALU/GNT_MEM.
module wb_arb_rr2
   import reg_write_scheduler_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] valid_i,
   input  logic [1:0] elig_i,
   output logic [1:0] gnt_o
);
   gnt_t       last_q;
   logic [1:0] req;

   // A requester competes only when valid, eligible and not in reset
   always_comb begin
      req = valid_i & elig_i & {2{~reset_i}};
      gnt_o = '0;
      gnt_o[GNT_MEM] = req[GNT_MEM] & (~req[GNT_ALU] | (last_q == GNT_ALU));
      gnt_o[GNT_ALU] = req[GNT_ALU] & (~req[GNT_MEM] | (last_q == GNT_MEM));
   end

   // Pointer remembers the last winner; moves only when a grant (transfer) happens
   always_ff @(posedge clk_i) begin
      if (reset_i)               last_q <= GNT_ALU;
      else if (gnt_o[GNT_MEM])   last_q <= GNT_MEM;
      else if (gnt_o[GNT_ALU])   last_q <= GNT_ALU;
   end
endmodule

// File: rtl/reg_write_scheduler.sv
// Owns the reg_file write port: arbitrates ALU vs load-return writes,
// tracks loads in flight and raises stall/error conditions.
module reg_write_scheduler
   import reg_write_scheduler_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  reset_i,
   reg_write_scheduler_if.slave  bus
);
   logic [NREG-1:0] busy_q, busy_d;
   logic            err_q, err_d;
   logic            write_q, write_d;
   addr_t           addr_q, addr_d;
   data_t           data_q, data_d;
   logic [1:0]      valid, elig, gnt;

   // MEM is always eligible; ALU waits while its target has a load pending
   always_comb begin
      valid = '0;
      elig  = '0;
      valid[GNT_ALU] = bus.alu_valid;
      valid[GNT_MEM] = bus.mem_valid;
      elig[GNT_ALU]  = ~busy_q[bus.alu_addr];
      elig[GNT_MEM]  = 1'b1;
   end

   wb_arb_rr2 u_arb (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_i (valid),
      .elig_i  (elig),
      .gnt_o   (gnt)
   );

   // Next write-port, scoreboard and error state; load set is applied last so it wins
   always_comb begin
      busy_d  = busy_q;
      err_d   = err_q;
      write_d = gnt[GNT_ALU] | gnt[GNT_MEM];
      addr_d  = addr_q;
      data_d  = data_q;
      if (gnt[GNT_MEM]) begin
         addr_d = bus.mem_addr;
         data_d = bus.mem_data;
         if (!busy_q[bus.mem_addr]) err_d = 1'b1;
         busy_d[bus.mem_addr] = 1'b0;
      end else if (gnt[GNT_ALU]) begin
         addr_d = bus.alu_addr;
         data_d = bus.alu_data;
      end
      if (bus.load_issue) begin
         if (busy_q[bus.load_addr]) err_d = 1'b1;
         busy_d[bus.load_addr] = 1'b1;
      end
   end

   // State registers; reset also discards any loads in flight
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_q  <= '0;
         err_q   <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         err_q   <= err_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Outputs: ready is the grant itself; stall covers operand hazards and a blocked ALU
   always_comb begin
      bus.alu_ready = gnt[GNT_ALU];
      bus.mem_ready = gnt[GNT_MEM];
      bus.stall     = (bus.chk_en1 & busy_q[bus.chk_addr1])
                    | (bus.chk_en2 & busy_q[bus.chk_addr2])
                    | (bus.alu_valid & ~gnt[GNT_ALU]);
      bus.write     = write_q;
      bus.inaddress = addr_q;
      bus.in_data   = data_q;
      bus.busy_mask = busy_q;
      bus.err       = err_q;
   end
endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed bench for reg_write_scheduler with hand-computed expectations.
module tb_reg_write_scheduler;
   import reg_write_scheduler_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   reg_write_scheduler_if bus ();

   reg_write_scheduler dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs are then changed 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
      bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_data = 0;
      bus.load_issue = 0; bus.load_addr = 0;
      bus.chk_en1 = 0; bus.chk_en2 = 0; bus.chk_addr1 = 0; bus.chk_addr2 = 0;
   endtask

   task automatic chk_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
      chk({tag, ".write"}, bus.write, 1);
      chk({tag, ".addr"}, bus.inaddress, a);
      chk({tag, ".data"}, bus.in_data, d);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle();
      reset = 1;
      tick(); tick();

      // Requests during reset are refused and ignored
      bus.alu_valid = 1; bus.alu_addr = 3'd6; bus.alu_data = 8'hEE;
      bus.load_issue = 1; bus.load_addr = 3'd1;
      settle();
      chk("rst.alu_ready", bus.alu_ready, 0);
      tick();
      idle();
      reset = 0;
      settle();
      chk("rst.write", bus.write, 0);
      chk("rst.addr", bus.inaddress, 0);
      chk("rst.data", bus.in_data, 0);
      chk("rst.busy", bus.busy_mask, 0);
      chk("rst.err", bus.err, 0);

      // 1: single ALU write, 1-cycle latency, then WRITE drops
      bus.alu_valid = 1; bus.alu_addr = 3'd3; bus.alu_data = 8'h2A;
      settle();
      chk("t1.alu_ready", bus.alu_ready, 1);
      tick();
      idle();
      settle();
      chk_wr("t1.wr", 3, 8'h2A);
      tick();
      chk("t1.write_fall", bus.write, 0);

      // 2: load to r5, operand hazard, then load return
      bus.load_issue = 1; bus.load_addr = 3'd5;
      tick();
      idle();
      bus.chk_en1 = 1; bus.chk_addr1 = 3'd5;
      settle();
      chk("t2.busy", bus.busy_mask, 8'h20);
      chk("t2.stall", bus.stall, 1);
      bus.mem_valid = 1; bus.mem_addr = 3'd5; bus.mem_data = 8'h77;
      settle();
      chk("t2.mem_ready", bus.mem_ready, 1);
      tick();
      bus.mem_valid = 0;
      settle();
      chk("t2.busy_clr", bus.busy_mask, 0);
      chk("t2.stall_clr", bus.stall, 0);
      chk_wr("t2.wr", 5, 8'h77);
      idle();
      chk("t2.err", bus.err, 0);

      // 3: conflict arbitration from a fresh pointer
      reset = 1;
      tick();
      reset = 0;
      bus.load_issue = 1; bus.load_addr = 3'd2;
      tick();
      bus.load_addr = 3'd3;
      tick();
      idle();
      bus.alu_valid = 1; bus.alu_addr = 3'd1; bus.alu_data = 8'h11;
      bus.mem_valid = 1; bus.mem_addr = 3'd2; bus.mem_data = 8'h22;
      settle();
      chk("t3.c1.mem_ready", bus.mem_ready, 1);
      chk("t3.c1.alu_ready", bus.alu_ready, 0);
      tick();
      // MEM immediately presents a second return: ALU's turn now
      bus.mem_addr = 3'd3; bus.mem_data = 8'h33;
      settle();
      chk_wr("t3.wr1", 2, 8'h22);
      chk("t3.c2.alu_ready", bus.alu_ready, 1);
      chk("t3.c2.mem_ready", bus.mem_ready, 0);
      tick();
      bus.alu_valid = 0;
      settle();
      chk_wr("t3.wr2", 1, 8'h11);
      chk("t3.c3.mem_ready", bus.mem_ready, 1);
      tick();
      idle();
      settle();
      chk_wr("t3.wr3", 3, 8'h33);
      chk("t3.busy", bus.busy_mask, 0);
      chk("t3.err", bus.err, 0);

      // 4: ALU blocked by pending load on r4 until the load returns
      bus.load_issue = 1; bus.load_addr = 3'd4;
      tick();
      idle();
      bus.alu_valid = 1; bus.alu_addr = 3'd4; bus.alu_data = 8'h44;
      settle();
      chk("t4.alu_ready", bus.alu_ready, 0);
      chk("t4.stall", bus.stall, 1);
      tick();
      chk("t4.no_write", bus.write, 0);
      bus.mem_valid = 1; bus.mem_addr = 3'd4; bus.mem_data = 8'h40;
      settle();
      chk("t4.mem_ready", bus.mem_ready, 1);
      chk("t4.alu_still_blk", bus.alu_ready, 0);
      tick();
      bus.mem_valid = 0;
      settle();
      chk_wr("t4.wr_mem", 4, 8'h40);
      chk("t4.alu_ready2", bus.alu_ready, 1);
      chk("t4.stall2", bus.stall, 0);
      tick();
      idle();
      settle();
      chk_wr("t4.wr_alu", 4, 8'h44);
      chk("t4.err", bus.err, 0);

      // 5a: double load to r6 raises sticky ERR
      bus.load_issue = 1; bus.load_addr = 3'd6;
      tick();
      chk("t5.err_pre", bus.err, 0);
      tick();
      idle();
      settle();
      chk("t5.err_dbl", bus.err, 1);
      chk("t5.busy6", bus.busy_mask, 8'h40);
      tick();
      chk("t5.err_sticky", bus.err, 1);
      reset = 1;
      tick();
      reset = 0;
      settle();
      chk("t5.err_rst", bus.err, 0);

      // 5b: MEM return to non-busy r0 still writes, raises ERR
      bus.mem_valid = 1; bus.mem_addr = 3'd0; bus.mem_data = 8'h5A;
      settle();
      chk("t5.mem_ready", bus.mem_ready, 1);
      tick();
      idle();
      settle();
      chk_wr("t5.wr0", 0, 8'h5A);
      chk("t5.err_mem", bus.err, 1);
      reset = 1;
      tick();
      reset = 0;

      // 6: set beats clear on r7, then reset mid-sequence
      bus.load_issue = 1; bus.load_addr = 3'd7;
      tick();
      bus.mem_valid = 1; bus.mem_addr = 3'd7; bus.mem_data = 8'h70;
      settle();
      chk("t6.mem_ready", bus.mem_ready, 1);
      tick();
      idle();
      settle();
      chk("t6.busy7", bus.busy_mask, 8'h80);
      chk_wr("t6.wr7", 7, 8'h70);
      bus.mem_valid = 1; bus.mem_addr = 3'd7; bus.mem_data = 8'h71;
      bus.alu_valid = 1; bus.alu_addr = 3'd1; bus.alu_data = 8'h01;
      reset = 1;
      settle();
      chk("t6.rst_mem_ready", bus.mem_ready, 0);
      chk("t6.rst_alu_ready", bus.alu_ready, 0);
      tick();
      bus.alu_valid = 0;
      bus.mem_valid = 0;
      reset = 0;
      settle();
      chk("t6.write", bus.write, 0);
      chk("t6.addr", bus.inaddress, 0);
      chk("t6.data", bus.in_data, 0);
      chk("t6.busy", bus.busy_mask, 0);
      chk("t6.err", bus.err, 0);

      // The discarded load's late return is now a protocol error
      bus.mem_valid = 1;
      settle();
      chk("t6.late_ready", bus.mem_ready, 1);
      tick();
      idle();
      settle();
      chk_wr("t6.late_wr", 7, 8'h71);
      chk("t6.late_err", bus.err, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
